// File: rtl/vga_pkg.sv
// Shared VGA constants: display timing, 12-bit colours and frame-buffer geometry/state encoding.
package vga_pkg;

  localparam int unsigned H_DISP  = 640;
  localparam int unsigned V_DISP  = 480;
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] BLUE  = 12'h00F;

  localparam int unsigned CELL_LOG2 = 3;
  localparam int unsigned FB_COLS   = H_DISP >> CELL_LOG2;
  localparam int unsigned FB_ROWS   = V_DISP >> CELL_LOG2;
  localparam int unsigned FB_DEPTH  = FB_COLS * FB_ROWS;
  localparam int unsigned FB_AW     = $clog2(FB_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_ram_1r1w.sv
// Simple dual-port 1-bit RAM: one write port, registered read-first read port.
module fb_ram_1r1w #(
  parameter int unsigned DEPTH = 4800,
  parameter int unsigned AW    = 13
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem [DEPTH];

  // Read sees the pre-write contents when both ports hit the same cell.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/vga_fb_pixel_source.sv
// 1-bit cell frame buffer feeding the VGA driver with 1-cycle pixel latency, plus clear engine.
// Optional cursor highlight of the last written cell when VGA_FB_CURSOR_EN is defined.
module vga_fb_pixel_source #(
  parameter int unsigned H_DISP    = 640,
  parameter int unsigned V_DISP    = 480,
  parameter int unsigned CELL_LOG2 = 3,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [11:0] pixel_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic        wr_bit,
  output logic        wr_drop,
  input  logic        clr_req,
  output logic        busy
);

  import vga_pkg::*;

  localparam int unsigned COLS  = H_DISP >> CELL_LOG2;
  localparam int unsigned ROWS  = V_DISP >> CELL_LOG2;
  localparam int unsigned DEPTH = COLS * ROWS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = 10 - CELL_LOG2;

  fb_state_e     state_q;
  logic [AW-1:0] clr_addr_q;
  logic          wr_drop_q;
  logic          rd_oor_q;
  logic          rd_bit;

  logic [CW-1:0] px_cell;
  logic [CW-1:0] py_cell;
  logic          rd_oor_d;
  logic [AW-1:0] rd_addr_d;
  logic          wr_fire;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr_d;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic          ram_wdata;
  logic [11:0]   cell_colour;

  assign busy     = (state_q == CLEAR);
  assign wr_ready = (state_q == IDLE);
  assign wr_drop  = wr_drop_q;

  // Read address; the constant multiply folds to a shift-add (y*80 = y<<6 + y<<4).
  assign px_cell   = pixel_x[9:CELL_LOG2];
  assign py_cell   = pixel_y[9:CELL_LOG2];
  assign rd_oor_d  = (pixel_x >= 10'(H_DISP)) || (pixel_y >= 10'(V_DISP));
  assign rd_addr_d = rd_oor_d ? '0 : AW'(32'(py_cell) * COLS + 32'(px_cell));

  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
  assign wr_addr_d   = AW'(32'(wr_y) * COLS + 32'(wr_x));

  // Clear engine owns the RAM write port whenever it runs.
  assign ram_we    = busy || (wr_fire && wr_in_range);
  assign ram_waddr = busy ? clr_addr_q : wr_addr_d;
  assign ram_wdata = busy ? 1'b0 : wr_bit;

  fb_ram_1r1w #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (vga_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_bit)
  );

  always_ff @(posedge vga_clk) begin
    if (sys_rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_drop_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      wr_drop_q <= wr_fire && !wr_in_range;
      rd_oor_q  <= rd_oor_d;
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
          end
        end
      endcase
    end
  end

  assign cell_colour = rd_bit ? FG_COLOR : BG_COLOR;

`ifdef VGA_FB_CURSOR_EN
  logic [6:0] cur_x_q;
  logic [5:0] cur_y_q;
  logic       cur_hit_q;

  // Cursor follows the last accepted in-range write; hit flag shares the read latency.
  always_ff @(posedge vga_clk) begin
    if (sys_rst_n) begin
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      cur_hit_q <= 1'b0;
    end else begin
      if (wr_fire && wr_in_range) begin
        cur_x_q <= wr_x;
        cur_y_q <= wr_y;
      end
      cur_hit_q <= (px_cell == CW'(cur_x_q)) && (py_cell == CW'(cur_y_q));
    end
  end

  assign pixel_data = (busy || rd_oor_q) ? BG_COLOR :
                      (cur_hit_q ? ~cell_colour : cell_colour);
`else
  assign pixel_data = (busy || rd_oor_q) ? BG_COLOR : cell_colour;
`endif

endmodule
